// File: rtl/fetch_unit.sv
// Instruction-fetch stage: latches the PC on a start pulse, issues one memory read and loads the returned word.
// Optional memory-timeout detection is built when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter int          ADDR_W      = 64,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
    parameter int          TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    input  logic              fault_clr,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_rvalid,
    output logic [31:0]       Instruction,
    output logic              instr_valid,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT must be in 2..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_FAULT
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == TO_LAST);

    // Any state change restarts the count; staying in WAIT/DRAIN means no response arrived.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (state_q == S_WAIT || state_q == S_DRAIN) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            instr_q       <= RESET_INSTR;
            instr_valid_q <= 1'b0;
            fault_code_q  <= FC_NONE;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_code_q  <= fault_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        fault_code_d  = fault_code_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    if (pc_in[1:0] == 2'b00) begin
                        addr_d  = pc_in;
                        state_d = S_REQ;
                    end else begin
                        fault_code_d = FC_MISALIGN;
                        state_d      = S_FAULT;
                    end
                end
            end
            S_REQ: begin
                // The request is already on the bus, so a flush must still absorb its response.
                state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = imem_rvalid ? S_IDLE : S_DRAIN;
                end else if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (timeout_hit) begin
                    fault_code_d = FC_TIMEOUT;
                    state_d      = S_FAULT;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    fault_code_d = FC_NONE;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_rd     = (state_q == S_REQ);
        imem_addr   = addr_q;
        busy        = (state_q != S_IDLE);
        fault       = (state_q == S_FAULT);
        Instruction = instr_q;
        instr_valid = instr_valid_q;
        fault_code  = fault_code_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [63:0] pc_in;
    logic        flush;
    logic        fault_clr;
    logic        imem_rd;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.ADDR_W(64), .RESET_INSTR(32'h0000_0013), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_in       (pc_in),
        .flush       (flush),
        .fault_clr   (fault_clr),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic [63:0] pc;
        logic        fl;
        logic        fc;
        logic        rv;
        logic [31:0] rd;
        logic        e_rd;
        logic [63:0] e_addr;
        logic [31:0] e_instr;
        logic        e_v;
        logic        e_busy;
        logic        e_fault;
        logic [1:0]  e_code;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_start = 1'b0;
        flush       = 1'b0;
        fault_clr   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".imem_rd"}, 64'(imem_rd), 64'd0);
        check({tag, ".imem_addr"}, imem_addr, 64'd0);
        check({tag, ".Instruction"}, 64'(Instruction), 64'h13);
        check({tag, ".instr_valid"}, 64'(instr_valid), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".fault"}, 64'(fault), 64'd0);
        check({tag, ".fault_code"}, 64'(fault_code), 64'd0);
    endtask

    initial begin
        int rd_cnt;
        int v_cnt;

        //           fs  pc      fl    fc    rv    rdata          rd    addr   instr          v     busy  flt   code
        vecs[0]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 64'h0,  32'h00000013, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{1'b1, 64'h42, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 64'h0,  32'h00000013, 1'b0, 1'b1, 1'b1, 2'b01};
        vecs[2]  = '{1'b1, 64'h40, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 64'h0,  32'h00000013, 1'b0, 1'b1, 1'b1, 2'b01};
        vecs[3]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 64'h0,  32'h00000013, 1'b0, 1'b1, 1'b1, 2'b01};
        vecs[4]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 64'h0,  32'h00000013, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 64'h0,  32'h00000013, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[6]  = '{1'b1, 64'h40, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 64'h40, 32'h00000013, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[7]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 64'h40, 32'h00000013, 1'b0, 1'b1, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 64'h40, 32'h00500093, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 64'h40, 32'h00500093, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[10] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 64'h40, 32'h00500093, 1'b0, 1'b0, 1'b0, 2'b00};

        reset = 1'b1;
        pc_in = 64'h0;
        idle_inputs();
        step();
        step();
        check_reset_outputs("reset");
        #2 reset = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            fetch_start = vecs[i].fs;
            pc_in       = vecs[i].pc;
            flush       = vecs[i].fl;
            fault_clr   = vecs[i].fc;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rd;
            step();
            check($sformatf("vec%0d.imem_rd", i), 64'(imem_rd), 64'(vecs[i].e_rd));
            check($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d.Instruction", i), 64'(Instruction), 64'(vecs[i].e_instr));
            check($sformatf("vec%0d.instr_valid", i), 64'(instr_valid), 64'(vecs[i].e_v));
            check($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("vec%0d.fault", i), 64'(fault), 64'(vecs[i].e_fault));
            check($sformatf("vec%0d.fault_code", i), 64'(fault_code), 64'(vecs[i].e_code));
        end
        idle_inputs();

        // Flush in WAIT; the late response must be swallowed.
        fetch_start = 1'b1;
        pc_in       = 64'h80;
        step();
        fetch_start = 1'b0;
        check("flush.req_rd", 64'(imem_rd), 64'd1);
        check("flush.req_addr", imem_addr, 64'h80);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.drain_busy_c3", 64'(busy), 64'd1);
        step();
        check("flush.drain_busy_c4", 64'(busy), 64'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        step();
        idle_inputs();
        check("flush.busy_after_resp", 64'(busy), 64'd0);
        check("flush.instr_valid", 64'(instr_valid), 64'd0);
        check("flush.Instruction", 64'(Instruction), 64'h00500093);

        // Second start while busy is dropped; only one request and one capture.
        rd_cnt      = 0;
        v_cnt       = 0;
        fetch_start = 1'b1;
        pc_in       = 64'hC0;
        step();
        for (int c = 1; c <= 10; c++) begin
            if (imem_rd) rd_cnt++;
            if (instr_valid) v_cnt++;
            if (c == 6) check("dbl.valid_cycle6", 64'(instr_valid), 64'd1);
            fetch_start = (c == 3);
            pc_in       = (c == 3) ? 64'hC4 : 64'hC0;
            imem_rvalid = (c == 5);
            imem_rdata  = 32'h12345678;
            step();
        end
        idle_inputs();
        check("dbl.rd_pulses", 64'(rd_cnt), 64'd1);
        check("dbl.valid_pulses", 64'(v_cnt), 64'd1);
        check("dbl.Instruction", 64'(Instruction), 64'h12345678);
        check("dbl.imem_addr", imem_addr, 64'hC0);

        // Reset while waiting; a response afterwards must not land.
        fetch_start = 1'b1;
        pc_in       = 64'h100;
        step();
        fetch_start = 1'b0;
        step();
        check("rst.in_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst.async");
        #1 reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hAAAA5555;
        step();
        idle_inputs();
        check_reset_outputs("rst.after_rvalid");

        // Memory never responds.
        fetch_start = 1'b1;
        pc_in       = 64'h200;
        step();
        fetch_start = 1'b0;
        step();
`ifdef FETCH_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 14) begin
                check("to.before_fault", 64'(fault), 64'd0);
                check("to.before_busy", 64'(busy), 64'd1);
            end
        end
        check("to.fault", 64'(fault), 64'd1);
        check("to.fault_code", 64'(fault_code), 64'd2);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("to.cleared_code", 64'(fault_code), 64'd0);
        check("to.cleared_busy", 64'(busy), 64'd0);
`else
        for (int k = 1; k <= 110; k++) begin
            step();
        end
        check("noto.busy", 64'(busy), 64'd1);
        check("noto.fault", 64'(fault), 64'd0);
        check("noto.fault_code", 64'(fault_code), 64'd0);
        reset = 1'b1;
        #2 reset = 1'b0;
        step();
        check("noto.recovered", 64'(busy), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
